hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl_if.sv | 48 ++++
 rtl/hazard_stall_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Stage-field and pipeline-control bundle between hazard_stall_ctrl and the datapath.
// master = sequencing controller, slave = datapath pipeline registers.
interface hazard_stall_ctrl_if;
  // ID stage
  logic [3:0] inst_curr_IFID_7_4_rs;
  logic [3:0] inst_curr_IFID_3_0_rt;
  logic [3:0] inst_curr_IFID_11_8_rd;
  logic       use_rs_ifid;
  logic       use_rt_ifid;
  logic       use_rd_ifid;
  logic       halt_ifid;
  // EX stage
  logic [3:0] rf_waddr_idex;
  logic       rf_wen_idex;
  logic       mem_read_idex;
  logic       branch_taken_ex;
  // MEM stage
  logic       dmem_req_exmem;
  logic       dmem_ready;
  // Controls back to the pipeline
  logic       pc_wen;
  logic       ifid_wen;
  logic       idex_wen;
  logic       exmem_wen;
  logic       ifid_flush;
  logic       idex_flush;
  logic       memwb_flush;
  logic       stall_active;
  logic       halted;

  modport master (
    input  inst_curr_IFID_7_4_rs, inst_curr_IFID_3_0_rt, inst_curr_IFID_11_8_rd,
    input  use_rs_ifid, use_rt_ifid, use_rd_ifid, halt_ifid,
    input  rf_waddr_idex, rf_wen_idex, mem_read_idex, branch_taken_ex,
    input  dmem_req_exmem, dmem_ready,
    output pc_wen, ifid_wen, idex_wen, exmem_wen,
    output ifid_flush, idex_flush, memwb_flush, stall_active, halted
  );

  modport slave (
    output inst_curr_IFID_7_4_rs, inst_curr_IFID_3_0_rt, inst_curr_IFID_11_8_rd,
    output use_rs_ifid, use_rt_ifid, use_rd_ifid, halt_ifid,
    output rf_waddr_idex, rf_wen_idex, mem_read_idex, branch_taken_ex,
    output dmem_req_exmem, dmem_ready,
    input  pc_wen, ifid_wen, idex_wen, exmem_wen,
    input  ifid_flush, idex_flush, memwb_flush, stall_active, halted
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, dmem wait states, branch flushes, halt drain.
// Optional: define HAZARD_STALL_COUNT_EN to add the saturating stall_count output.
module hazard_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,  // 1..7
  parameter int unsigned DRAIN_CYCLES = 3   // 1..7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_ctrl_if.master  bus
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0]          stall_count
`endif
);

  typedef enum logic [2:0] {
    S_RUN,
    S_MEM_WAIT,
    S_FLUSH,
    S_HALT_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic pc_wen, ifid_wen, idex_wen, exmem_wen;
  logic ifid_flush, idex_flush, memwb_flush;
  logic halted;
  logic stall_active;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic dmem_wait;
  logic ex_load_dst;
  logic load_use;

  assign dmem_wait   = bus.dmem_req_exmem && !bus.dmem_ready;
  // A load targeting r0 produces nothing a consumer could wait for.
  assign ex_load_dst = bus.mem_read_idex && bus.rf_wen_idex && (bus.rf_waddr_idex != 4'd0);
  assign load_use    = ex_load_dst &&
                       ((bus.use_rs_ifid && (bus.inst_curr_IFID_7_4_rs  == bus.rf_waddr_idex)) ||
                        (bus.use_rt_ifid && (bus.inst_curr_IFID_3_0_rt  == bus.rf_waddr_idex)) ||
                        (bus.use_rd_ifid && (bus.inst_curr_IFID_11_8_rd == bus.rf_waddr_idex)));

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written below gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    idex_wen    = 1'b1;
    exmem_wen   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (dmem_wait) begin
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_wen    = 1'b0;
          exmem_wen   = 1'b0;
          memwb_flush = 1'b1;
          state_d     = S_MEM_WAIT;
        end else if (bus.branch_taken_ex) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (load_use) begin
          // One bubble into EX; the load moves on and the match clears next cycle.
          pc_wen     = 1'b0;
          ifid_wen   = 1'b0;
          idex_flush = 1'b1;
        end else if (bus.halt_ifid) begin
          pc_wen     = 1'b0;
          ifid_wen   = 1'b0;
          idex_flush = 1'b1;
          // The detection cycle itself counts as the first drain cycle.
          if (DRAIN_CYCLES > 1) begin
            state_d = S_HALT_DRAIN;
            cnt_d   = DRAIN_INIT;
          end else begin
            state_d = S_HALTED;
          end
        end
      end

      S_MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_wen    = 1'b0;
          exmem_wen   = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end

      S_FLUSH: begin
        if (dmem_wait) begin
          // Remaining flush count is dropped: IF/ID and ID/EX already hold bubbles.
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_wen    = 1'b0;
          exmem_wen   = 1'b0;
          memwb_flush = 1'b1;
          state_d     = S_MEM_WAIT;
          cnt_d       = '0;
        end else begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
      end

      S_HALT_DRAIN: begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        idex_flush = 1'b1;
        if (dmem_wait) begin
          // Older instructions still draining must respect the memory wait.
          exmem_wen   = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = S_HALTED;
            cnt_d   = '0;
          end
        end
      end

      S_HALTED: begin
        pc_wen    = 1'b0;
        ifid_wen  = 1'b0;
        idex_wen  = 1'b0;
        exmem_wen = 1'b0;
        halted    = 1'b1;
      end

      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // HALTED holds everything by design, so it is not reported as a stall.
  assign stall_active = rst_n && (state_q != S_HALTED) &&
                        (!(pc_wen && ifid_wen && idex_wen && exmem_wen) ||
                         ifid_flush || idex_flush || memwb_flush);

  // ---------------------------------------------------------------------------
  // Output drive; reset forces every register to load a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!rst_n) begin
      bus.pc_wen      = 1'b0;
      bus.ifid_wen    = 1'b0;
      bus.idex_wen    = 1'b0;
      bus.exmem_wen   = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.memwb_flush = 1'b1;
      bus.halted      = 1'b0;
    end else begin
      bus.pc_wen      = pc_wen;
      bus.ifid_wen    = ifid_wen;
      bus.idex_wen    = idex_wen;
      bus.exmem_wen   = exmem_wen;
      bus.ifid_flush  = ifid_flush;
      bus.idex_flush  = idex_flush;
      bus.memwb_flush = memwb_flush;
      bus.halted      = halted;
    end
  end

  assign bus.stall_active = stall_active;

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_active && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (FLUSH_CYCLES=2, DRAIN_CYCLES=3).
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus ();
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  hazard_stall_ctrl #(
    .FLUSH_CYCLES (2),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  // Output vector: {pc,ifid,idex,exmem}_wen, {ifid,idex,memwb}_flush, stall_active, halted
  localparam logic [8:0] O_NORMAL  = 9'b1111_000_0_0;
  localparam logic [8:0] O_MEMWAIT = 9'b0000_001_1_0;
  localparam logic [8:0] O_BRFLUSH = 9'b1111_110_1_0;
  localparam logic [8:0] O_BUBBLE  = 9'b0011_010_1_0;  // load-use and halt drain
  localparam logic [8:0] O_DRWAIT  = 9'b0010_011_1_0;  // drain during dmem wait
  localparam logic [8:0] O_HALTED  = 9'b0000_000_0_1;
  localparam logic [8:0] O_RESET   = 9'b0000_111_0_0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [8:0] outs();
    return {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen,
            bus.ifid_flush, bus.idex_flush, bus.memwb_flush,
            bus.stall_active, bus.halted};
  endfunction

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inst_curr_IFID_7_4_rs  = 4'd0;
    bus.inst_curr_IFID_3_0_rt  = 4'd0;
    bus.inst_curr_IFID_11_8_rd = 4'd0;
    bus.use_rs_ifid     = 1'b0;
    bus.use_rt_ifid     = 1'b0;
    bus.use_rd_ifid     = 1'b0;
    bus.halt_ifid       = 1'b0;
    bus.rf_waddr_idex   = 4'd0;
    bus.rf_wen_idex     = 1'b0;
    bus.mem_read_idex   = 1'b0;
    bus.branch_taken_ex = 1'b0;
    bus.dmem_req_exmem  = 1'b0;
    bus.dmem_ready      = 1'b0;
  endtask

  task automatic load_in_ex(input logic [3:0] waddr);
    bus.mem_read_idex = 1'b1;
    bus.rf_wen_idex   = 1'b1;
    bus.rf_waddr_idex = waddr;
  endtask

  task automatic do_reset(input string tag);
    tick();
    rst_n = 1'b0;
    idle();
    #1 check({tag, "_during_reset"}, 16'(outs()), 16'(O_RESET));
    tick();
    rst_n = 1'b1;
    #1 check({tag, "_after_reset"}, 16'(outs()), 16'(O_NORMAL));
`ifdef HAZARD_STALL_COUNT_EN
    check({tag, "_count_cleared"}, stall_count, 16'd0);
`endif
  endtask

  initial begin
    idle();
    do_reset("init");

    // ---- load-use ----
    tick(); load_in_ex(4'd3); bus.inst_curr_IFID_7_4_rs = 4'd3; bus.use_rs_ifid = 1'b1;
    #1 check("lu_rs_stall", 16'(outs()), 16'(O_BUBBLE));
    tick(); bus.mem_read_idex = 1'b0; bus.rf_wen_idex = 1'b0;
    #1 check("lu_after_bubble", 16'(outs()), 16'(O_NORMAL));
    tick(); load_in_ex(4'd0); bus.inst_curr_IFID_7_4_rs = 4'd0;
    #1 check("lu_r0_no_stall", 16'(outs()), 16'(O_NORMAL));
    tick(); idle(); load_in_ex(4'd5); bus.inst_curr_IFID_11_8_rd = 4'd5; bus.use_rd_ifid = 1'b1;
    #1 check("lu_store_rd", 16'(outs()), 16'(O_BUBBLE));
    tick(); bus.use_rd_ifid = 1'b0; bus.inst_curr_IFID_3_0_rt = 4'd5;
    #1 check("lu_unused_field", 16'(outs()), 16'(O_NORMAL));
    tick(); bus.use_rt_ifid = 1'b1; bus.mem_read_idex = 1'b0;
    #1 check("lu_not_load", 16'(outs()), 16'(O_NORMAL));

    // ---- dmem wait, 3 cycles ----
    do_reset("dm");
    tick(); bus.dmem_req_exmem = 1'b1; bus.dmem_ready = 1'b0;
    #1 check("dm_wait1", 16'(outs()), 16'(O_MEMWAIT));
    tick(); #1 check("dm_wait2", 16'(outs()), 16'(O_MEMWAIT));
    tick(); #1 check("dm_wait3", 16'(outs()), 16'(O_MEMWAIT));
    tick(); bus.dmem_ready = 1'b1;
    #1 check("dm_release", 16'(outs()), 16'(O_NORMAL));
`ifdef HAZARD_STALL_COUNT_EN
    check("dm_count3", stall_count, 16'd3);
`endif
    tick(); #1 check("dm_ready_first", 16'(outs()), 16'(O_NORMAL));
    tick(); idle();
    #1 check("dm_idle", 16'(outs()), 16'(O_NORMAL));

    // ---- taken branch, 2 flush cycles, load-use ignored ----
    tick(); bus.branch_taken_ex = 1'b1; load_in_ex(4'd3);
    bus.inst_curr_IFID_7_4_rs = 4'd3; bus.use_rs_ifid = 1'b1;
    #1 check("br_flush1", 16'(outs()), 16'(O_BRFLUSH));
    tick(); bus.branch_taken_ex = 1'b0;
    #1 check("br_flush2", 16'(outs()), 16'(O_BRFLUSH));
    tick(); idle();
    #1 check("br_done", 16'(outs()), 16'(O_NORMAL));

    // ---- branch and dmem wait together ----
    tick(); bus.branch_taken_ex = 1'b1; bus.dmem_req_exmem = 1'b1; bus.dmem_ready = 1'b0;
    #1 check("brdm_wait", 16'(outs()), 16'(O_MEMWAIT));
    tick(); bus.dmem_ready = 1'b1;
    #1 check("brdm_ready", 16'(outs()), 16'(O_NORMAL));
    tick(); bus.dmem_req_exmem = 1'b0; bus.dmem_ready = 1'b0;
    #1 check("brdm_flush1", 16'(outs()), 16'(O_BRFLUSH));
    tick(); bus.branch_taken_ex = 1'b0;
    #1 check("brdm_flush2", 16'(outs()), 16'(O_BRFLUSH));
    tick(); #1 check("brdm_done", 16'(outs()), 16'(O_NORMAL));

    // ---- dmem wait arriving during FLUSH cuts it short ----
    tick(); bus.branch_taken_ex = 1'b1;
    #1 check("fl_flush1", 16'(outs()), 16'(O_BRFLUSH));
    tick(); bus.branch_taken_ex = 1'b0; bus.dmem_req_exmem = 1'b1;
    #1 check("fl_dm_wait", 16'(outs()), 16'(O_MEMWAIT));
    tick(); bus.dmem_ready = 1'b1;
    #1 check("fl_dm_ready", 16'(outs()), 16'(O_NORMAL));
    tick(); idle();
    #1 check("fl_count_lost", 16'(outs()), 16'(O_NORMAL));

    // ---- halt drain with one wait cycle ----
    do_reset("hl");
    tick(); bus.halt_ifid = 1'b1;
    #1 check("hl_detect", 16'(outs()), 16'(O_BUBBLE));
    tick(); #1 check("hl_drain1", 16'(outs()), 16'(O_BUBBLE));
    tick(); bus.dmem_req_exmem = 1'b1;
    #1 check("hl_drain_wait", 16'(outs()), 16'(O_DRWAIT));
    tick(); bus.dmem_req_exmem = 1'b0;
    #1 check("hl_drain2", 16'(outs()), 16'(O_BUBBLE));
    tick(); #1 check("hl_halted", 16'(outs()), 16'(O_HALTED));
    tick(); bus.branch_taken_ex = 1'b1; bus.dmem_req_exmem = 1'b1;
    #1 check("hl_sticky1", 16'(outs()), 16'(O_HALTED));
    tick(); #1 check("hl_sticky2", 16'(outs()), 16'(O_HALTED));
    do_reset("hl_exit");

    // ---- reset mid-FLUSH ----
    tick(); bus.branch_taken_ex = 1'b1;
    #1 check("rf_flush1", 16'(outs()), 16'(O_BRFLUSH));
    tick(); bus.branch_taken_ex = 1'b0; rst_n = 1'b0;
    #1 check("rf_in_reset", 16'(outs()), 16'(O_RESET));
    tick(); rst_n = 1'b1;
    #1 check("rf_released", 16'(outs()), 16'(O_NORMAL));
`ifdef HAZARD_STALL_COUNT_EN
    check("rf_count0", stall_count, 16'd0);
`endif
    tick(); #1 check("rf_no_residue", 16'(outs()), 16'(O_NORMAL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
